// File: rtl/reset_sequencer.sv
// reset_sequencer: releases NUM_DOM active-low domain resets one at a time,
// in index order. Each release after the first waits for the ready
// acknowledge of the previously released domain plus a fixed gap. If a
// domain does not acknowledge in time, every domain is put back into reset
// and a sticky timeout flag is raised.
module reset_sequencer #(
  parameter int unsigned NUM_DOM     = 3,
  parameter int unsigned HOLD_CYC    = 4,
  parameter int unsigned GAP_CYC     = 2,
  parameter int unsigned ACK_TIMEOUT = 8,
  localparam int unsigned IDX_W      = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sync_rst_n,
  input  logic               sw_rst_req,
  input  logic [NUM_DOM-1:0] done_i,
  output logic [NUM_DOM-1:0] dom_rst_n,
  output logic               seq_busy,
  output logic               all_ready,
  output logic               err_timeout,
  output logic [IDX_W-1:0]   fault_dom
);

  // The counter is shared by the hold, gap and acknowledge-timeout phases.
  localparam int unsigned MAX_HG  = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
  localparam int unsigned MAX_CYC = (MAX_HG > ACK_TIMEOUT) ? MAX_HG : ACK_TIMEOUT;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DOM - 1);

  typedef enum logic [2:0] {
    ST_ASSERT   = 3'd0,
    ST_WAIT_ACK = 3'd1,
    ST_GAP      = 3'd2,
    ST_READY    = 3'd3,
    ST_FAULT    = 3'd4
  } state_e;

  state_e             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [NUM_DOM-1:0] dom_rst_n_q;
  logic               seq_busy_q;
  logic               all_ready_q;
  logic               err_timeout_q;
  logic [IDX_W-1:0]   fault_dom_q;

  // Sequencer FSM: reset first, then abort, then the per-state transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_ASSERT;
      idx_q         <= '0;
      cnt_q         <= '0;
      dom_rst_n_q   <= '0;
      seq_busy_q    <= 1'b1;
      all_ready_q   <= 1'b0;
      err_timeout_q <= 1'b0;
      fault_dom_q   <= '0;
    end else if (!sync_rst_n || sw_rst_req) begin
      // Abort: back to a fully asserted state and a fresh hold count.
      state_q       <= ST_ASSERT;
      idx_q         <= '0;
      cnt_q         <= '0;
      dom_rst_n_q   <= '0;
      seq_busy_q    <= 1'b1;
      all_ready_q   <= 1'b0;
      err_timeout_q <= 1'b0;
      fault_dom_q   <= '0;
    end else begin
      case (state_q)
        ST_ASSERT: begin
          dom_rst_n_q <= '0;
          if (cnt_q == HOLD_LAST) begin
            dom_rst_n_q <= NUM_DOM'(1);
            cnt_q       <= '0;
            state_q     <= ST_WAIT_ACK;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        ST_WAIT_ACK: begin
          // The acknowledge is checked first so it wins over a coincident timeout.
          if (done_i[idx_q]) begin
            if (idx_q == IDX_LAST) begin
              state_q     <= ST_READY;
              seq_busy_q  <= 1'b0;
              all_ready_q <= 1'b1;
            end else begin
              cnt_q   <= '0;
              state_q <= ST_GAP;
            end
          end else if (cnt_q == ACK_LAST) begin
            state_q       <= ST_FAULT;
            dom_rst_n_q   <= '0;
            fault_dom_q   <= idx_q;
            err_timeout_q <= 1'b1;
            seq_busy_q    <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        ST_GAP: begin
          if (cnt_q == GAP_LAST) begin
            idx_q       <= idx_q + IDX_W'(1);
            dom_rst_n_q <= dom_rst_n_q | (NUM_DOM'(1) << (idx_q + IDX_W'(1)));
            cnt_q       <= '0;
            state_q     <= ST_WAIT_ACK;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        ST_READY: begin
          dom_rst_n_q <= '1;
        end

        ST_FAULT: begin
          dom_rst_n_q <= '0;
        end

        default: begin
          state_q     <= ST_ASSERT;
          idx_q       <= '0;
          cnt_q       <= '0;
          dom_rst_n_q <= '0;
          seq_busy_q  <= 1'b1;
          all_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign dom_rst_n   = dom_rst_n_q;
  assign seq_busy    = seq_busy_q;
  assign all_ready   = all_ready_q;
  assign err_timeout = err_timeout_q;
  assign fault_dom   = fault_dom_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed test-plan scenarios plus randomized stimulus,
// every cycle compared against a release-count reference model.
module tb_reset_sequencer;

  localparam int unsigned NUM_DOM     = 3;
  localparam int unsigned HOLD_CYC    = 4;
  localparam int unsigned GAP_CYC     = 2;
  localparam int unsigned ACK_TIMEOUT = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sync_rst_n = 1'b0;
  logic       sw_rst_req = 1'b0;
  logic [2:0] done_i = 3'b000;
  logic [2:0] dom_rst_n;
  logic       seq_busy;
  logic       all_ready;
  logic       err_timeout;
  logic [1:0] fault_dom;

  int n_checks = 0;
  int n_errors = 0;

  // Responder: when enabled, done_i follows the released domains under a mask.
  bit         resp_en = 1'b0;
  logic [2:0] resp_mask = 3'b111;

  reset_sequencer #(
    .NUM_DOM    (NUM_DOM),
    .HOLD_CYC   (HOLD_CYC),
    .GAP_CYC    (GAP_CYC),
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sync_rst_n (sync_rst_n),
    .sw_rst_req (sw_rst_req),
    .done_i     (done_i),
    .dom_rst_n  (dom_rst_n),
    .seq_busy   (seq_busy),
    .all_ready  (all_ready),
    .err_timeout(err_timeout),
    .fault_dom  (fault_dom)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: how many domains are released, consecutive high
  // samples seen, age within the current wait/gap, and terminal flags.
  int m_hold  = 0;
  int m_nrel  = 0;
  int m_age   = 0;
  int m_fidx  = 0;
  bit m_gap   = 1'b0;
  bit m_ready = 1'b0;
  bit m_fault = 1'b0;

  function automatic void model_edge();
    if (reset || !sync_rst_n || sw_rst_req) begin
      m_hold = 0; m_nrel = 0; m_age = 0; m_fidx = 0;
      m_gap = 1'b0; m_ready = 1'b0; m_fault = 1'b0;
    end else if (m_fault || m_ready) begin
      // terminal until reset or abort
    end else if (m_nrel == 0) begin
      m_hold++;
      if (m_hold == int'(HOLD_CYC)) begin
        m_nrel = 1;
        m_age  = 0;
      end
    end else if (m_gap) begin
      m_age++;
      if (m_age == int'(GAP_CYC)) begin
        m_nrel++;
        m_gap = 1'b0;
        m_age = 0;
      end
    end else if (done_i[m_nrel-1]) begin
      if (m_nrel == int'(NUM_DOM)) m_ready = 1'b1;
      else begin
        m_gap = 1'b1;
        m_age = 0;
      end
    end else begin
      m_age++;
      if (m_age == int'(ACK_TIMEOUT)) begin
        m_fault = 1'b1;
        m_fidx  = m_nrel - 1;
      end
    end
  endfunction

  task automatic compare_all();
    logic [2:0] e_dom;
    e_dom = m_fault ? 3'b000 : 3'((32'd1 << m_nrel) - 32'd1);
    check("dom_rst_n", 32'(dom_rst_n), 32'(e_dom));
    check("seq_busy", 32'(seq_busy), 32'(!(m_fault || m_ready)));
    check("all_ready", 32'(all_ready), 32'(m_ready));
    check("err_timeout", 32'(err_timeout), 32'(m_fault));
    check("fault_dom", 32'(fault_dom), m_fault ? 32'(m_fidx) : 32'd0);
  endtask

  // One clock edge: advance the model, sample outputs just after the edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
    if (resp_en) done_i = dom_rst_n & resp_mask;
  endtask

  task automatic start();
    reset = 1'b1; sw_rst_req = 1'b0; sync_rst_n = 1'b0; done_i = 3'b000; resp_en = 1'b0;
    step();
    check("rst_dom", 32'(dom_rst_n), 32'd0);
    check("rst_busy", 32'(seq_busy), 32'd1);
    reset = 1'b0;
  endtask

  initial begin
    // Normal bring-up; k is the index of the edge just taken.
    start();
    sync_rst_n = 1'b1; resp_en = 1'b1; resp_mask = 3'b111;
    for (int k = 0; k <= 10; k++) begin
      step();
      if (k == 2) check("up_pre_d0", 32'(dom_rst_n), 32'b000);
      if (k == 3) check("up_d0", 32'(dom_rst_n), 32'b001);
      if (k == 5) check("up_gap0", 32'(dom_rst_n), 32'b001);
      if (k == 6) check("up_d1", 32'(dom_rst_n), 32'b011);
      if (k == 9) begin
        check("up_d2", 32'(dom_rst_n), 32'b111);
        check("up_busy_d2", 32'(seq_busy), 32'd1);
      end
      if (k == 10) begin
        check("up_ready", 32'(all_ready), 32'd1);
        check("up_busy_ready", 32'(seq_busy), 32'd0);
      end
    end

    // Reset beats a coincident abort while in READY.
    resp_en = 1'b0;
    reset = 1'b1; sw_rst_req = 1'b1; sync_rst_n = 1'b0;
    step();
    check("prio_dom", 32'(dom_rst_n), 32'd0);
    check("prio_busy", 32'(seq_busy), 32'd1);
    check("prio_ready", 32'(all_ready), 32'd0);
    check("prio_err", 32'(err_timeout), 32'd0);
    check("prio_fdom", 32'(fault_dom), 32'd0);
    reset = 1'b0; sw_rst_req = 1'b0;

    // Hold restart: one low sample at edge 3 restarts the count.
    start();
    for (int k = 0; k <= 8; k++) begin
      sync_rst_n = (k != 3);
      step();
      if (k == 6) check("hold_not_yet", 32'(dom_rst_n), 32'b000);
      if (k == 7) check("hold_release", 32'(dom_rst_n), 32'b001);
    end

    // Timeout on domain 1, then software re-sequence.
    start();
    sync_rst_n = 1'b1; resp_en = 1'b1; resp_mask = 3'b001;
    for (int k = 0; k <= 14; k++) begin
      step();
      if (k == 6) check("to_d1", 32'(dom_rst_n), 32'b011);
      if (k == 13) begin
        check("to_pre_err", 32'(err_timeout), 32'd0);
        check("to_pre_dom", 32'(dom_rst_n), 32'b011);
      end
      if (k == 14) begin
        check("to_err", 32'(err_timeout), 32'd1);
        check("to_fdom", 32'(fault_dom), 32'd1);
        check("to_dom", 32'(dom_rst_n), 32'b000);
        check("to_busy", 32'(seq_busy), 32'd0);
      end
    end
    sw_rst_req = 1'b1;
    step();
    check("sw_err_clr", 32'(err_timeout), 32'd0);
    check("sw_busy", 32'(seq_busy), 32'd1);
    sw_rst_req = 1'b0; resp_mask = 3'b111;
    for (int k = 0; k < 11; k++) step();
    check("sw_reseq_ready", 32'(all_ready), 32'd1);

    // Ack on the timeout edge wins; early done_i[2] is ignored.
    start();
    sync_rst_n = 1'b1; done_i = 3'b100;
    for (int k = 0; k <= 13; k++) begin
      if (k == 11) done_i = 3'b101;
      step();
      if (k == 10) check("sim_ignore_d2", 32'(dom_rst_n), 32'b001);
      if (k == 11) begin
        check("sim_no_err", 32'(err_timeout), 32'd0);
        check("sim_busy", 32'(seq_busy), 32'd1);
      end
      if (k == 13) check("sim_d1", 32'(dom_rst_n), 32'b011);
    end

    // Abort while in GAP after domain 0 acknowledges.
    start();
    sync_rst_n = 1'b1; resp_en = 1'b1; resp_mask = 3'b111;
    for (int k = 0; k <= 9; k++) begin
      sw_rst_req = (k == 5);
      step();
      if (k == 5) begin
        check("ab_dom", 32'(dom_rst_n), 32'b000);
        check("ab_busy", 32'(seq_busy), 32'd1);
      end
      if (k == 8) check("ab_hold", 32'(dom_rst_n), 32'b000);
      if (k == 9) check("ab_release", 32'(dom_rst_n), 32'b001);
    end
    sw_rst_req = 1'b0;

    // Randomized stimulus against the model.
    resp_en = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      reset      = ($urandom_range(0, 299) == 0);
      sync_rst_n = ($urandom_range(0, 59) != 0);
      sw_rst_req = ($urandom_range(0, 99) == 0);
      done_i     = 3'($urandom) & 3'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
